// File: rtl/serial_link_scheduler_if.sv
// Interface bundling the channel inputs and the serial-link outputs of
// serial_link_scheduler. The optional overrun signals exist only when
// SCHED_OVERRUN_EN is defined.
interface serial_link_scheduler_if #(
    parameter int N_CH   = 4,
    parameter int DATA_W = 22
);
    localparam int CW = (N_CH > 1) ? $clog2(N_CH) : 1;

    logic [N_CH-1:0]        ch_valid;
    logic [N_CH*DATA_W-1:0] ch_data;
    logic                   serial_out;
    logic                   frame_sync_out;
    logic [CW-1:0]          active_ch;
    logic                   busy;
    logic [N_CH-1:0]        ch_pending;
`ifdef SCHED_OVERRUN_EN
    logic                   overrun_clr;
    logic [N_CH-1:0]        overrun_flags;
`endif

    // Sample producer side (filter channels)
    modport master (
        output ch_valid, ch_data,
        input  serial_out, frame_sync_out, active_ch, busy, ch_pending
`ifdef SCHED_OVERRUN_EN
        , output overrun_clr
        , input  overrun_flags
`endif
    );

    // Scheduler side
    modport slave (
        input  ch_valid, ch_data,
        output serial_out, frame_sync_out, active_ch, busy, ch_pending
`ifdef SCHED_OVERRUN_EN
        , input  overrun_clr
        , output overrun_flags
`endif
    );
endinterface

// File: rtl/serial_link_scheduler.sv
// serial_link_scheduler: transmit-side scheduler for the shared serial link.
// Each channel owns a one-deep holding register; a round-robin arbiter picks
// one pending channel and the FSM sends its word MSB first with frame_sync_out
// high for exactly DATA_W cycles, followed by GAP_CYCLES idle cycles.
// Optional feature macro: SCHED_OVERRUN_EN (sticky per-channel overrun flags).
module serial_link_scheduler #(
    parameter int N_CH       = 4,
    parameter int DATA_W     = 22,
    parameter int GAP_CYCLES = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    serial_link_scheduler_if.slave bus
);
    localparam int CW = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam int BW = $clog2(DATA_W);
    localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

    state_t              state_q;
    logic [N_CH-1:0]     pending_q;
    logic [N_CH-1:0]     pending_d;
    logic [N_CH-1:0]     grant_onehot;
    logic [CW-1:0]       last_grant_q;
    logic [CW-1:0]       grant_idx;
    logic [CW-1:0]       active_q;
    logic                grant_found;
    logic                arb_slot;
    logic                grant_now;
    logic [DATA_W-1:0]   hold_word [N_CH];
    // Only the bits still to be sent; the MSB goes straight to serial_q on load.
    logic [DATA_W-2:0]   shift_q;
    logic [BW-1:0]       bit_cnt_q;
    logic [GW-1:0]       gap_cnt_q;
    logic                serial_q;
    logic                sync_q;

    // Arbitration happens when idle or on the last gap cycle, so back-to-back
    // frames keep a fixed DATA_W+GAP_CYCLES period.
    assign arb_slot  = (state_q == ST_IDLE) ||
                       ((state_q == ST_GAP) && (gap_cnt_q == GW'(GAP_CYCLES - 1)));
    assign grant_now = arb_slot && grant_found;

    // Round-robin search from last_grant+1; scanning downward lets the nearest hit win.
    always_comb begin
        int idx;
        idx         = 0;
        grant_found = 1'b0;
        grant_idx   = last_grant_q;
        for (int off = N_CH; off >= 1; off--) begin
            idx = (int'(last_grant_q) + off) % N_CH;
            if (pending_q[idx]) begin
                grant_found = 1'b1;
                grant_idx   = CW'(idx);
            end
        end
    end

    // Per-channel holding register: accept a sample when empty, or when the
    // old word leaves on this same edge; otherwise the new sample is dropped.
    generate
        for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
            logic              store_en;
            logic [DATA_W-1:0] word_q;

            assign grant_onehot[gi] = grant_now && (grant_idx == CW'(gi));
            assign store_en         = bus.ch_valid[gi] && (!pending_q[gi] || grant_onehot[gi]);
            assign pending_d[gi]    = bus.ch_valid[gi] || (pending_q[gi] && !grant_onehot[gi]);
            assign hold_word[gi]    = word_q;

            // Capture the channel slice into its holding register
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    word_q <= '0;
                end else if (store_en) begin
                    word_q <= bus.ch_data[gi*DATA_W +: DATA_W];
                end
            end
        end
    endgenerate

    // Pending bits track holding-register occupancy
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending_q <= '0;
        end else begin
            pending_q <= pending_d;
        end
    end

    // Frame FSM with registered serial, sync and active-channel outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            last_grant_q <= CW'(N_CH - 1);
            active_q     <= '0;
            shift_q      <= '0;
            bit_cnt_q    <= '0;
            gap_cnt_q    <= '0;
            serial_q     <= 1'b0;
            sync_q       <= 1'b0;
        end else begin
            case (state_q)
                ST_SHIFT: begin
                    if (bit_cnt_q == BW'(DATA_W - 1)) begin
                        sync_q    <= 1'b0;
                        serial_q  <= 1'b0;
                        gap_cnt_q <= '0;
                        state_q   <= ST_GAP;
                    end else begin
                        serial_q  <= shift_q[DATA_W-2];
                        shift_q   <= {shift_q[DATA_W-3:0], 1'b0};
                        bit_cnt_q <= bit_cnt_q + BW'(1);
                    end
                end
                default: begin
                    // IDLE, and GAP once its last cycle is reached
                    if (state_q == ST_GAP && !arb_slot) begin
                        gap_cnt_q <= gap_cnt_q + GW'(1);
                    end else if (grant_now) begin
                        last_grant_q <= grant_idx;
                        active_q     <= grant_idx;
                        serial_q     <= hold_word[grant_idx][DATA_W-1];
                        shift_q      <= hold_word[grant_idx][DATA_W-2:0];
                        sync_q       <= 1'b1;
                        bit_cnt_q    <= '0;
                        state_q      <= ST_SHIFT;
                    end else begin
                        serial_q <= 1'b0;
                        sync_q   <= 1'b0;
                        state_q  <= ST_IDLE;
                    end
                end
            endcase
        end
    end

`ifdef SCHED_OVERRUN_EN
    logic [N_CH-1:0] drop;
    logic [N_CH-1:0] overrun_q;

    generate
        for (genvar gi = 0; gi < N_CH; gi++) begin : g_drop
            assign drop[gi] = bus.ch_valid[gi] && pending_q[gi] && !grant_onehot[gi];
        end
    endgenerate

    // Sticky overrun flags; a drop in the clear cycle still sets its flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overrun_q <= '0;
        end else begin
            overrun_q <= (bus.overrun_clr ? '0 : overrun_q) | drop;
        end
    end

    assign bus.overrun_flags = overrun_q;
`endif

    assign bus.serial_out     = serial_q;
    assign bus.frame_sync_out = sync_q;
    assign bus.active_ch      = active_q;
    assign bus.busy           = (state_q != ST_IDLE);
    assign bus.ch_pending     = pending_q;
endmodule
